// File: rtl/otbn_pkg.sv
// Shared OTBN types for the DMEM arbiter slice.
//   ExtWLEN         : width of a DMEM word including integrity bits
//   DmemAddrMaxW    : width of the address field carried in a queued host request
//   dmem_owner_e    : who receives the memory response of the previous cycle
//   dmem_host_req_t : one queued host request (addr, write, wdata, wmask)
//   vbits()         : address/pointer width for a given number of items (min 1)
package otbn_pkg;

  localparam int unsigned ExtWLEN      = 312;
  localparam int unsigned DmemAddrMaxW = 32;

  typedef enum logic [1:0] {
    OwnerNone,
    OwnerCore,
    OwnerHost,
    OwnerHostBlocked
  } dmem_owner_e;

  typedef struct packed {
    logic [DmemAddrMaxW-1:0] addr;
    logic                    write;
    logic [ExtWLEN-1:0]      wdata;
    logic [ExtWLEN-1:0]      wmask;
  } dmem_host_req_t;

  function automatic int unsigned vbits(int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/otbn_dmem_host_fifo.sv
// Host request queue for the OTBN DMEM arbiter.
//   clk_i, rst_i  : clock, synchronous active-high reset (pointers/count only)
//   push_i        : enqueue push_data_i (ignored when full)
//   pop_i         : dequeue head (ignored when empty)
//   head_o        : current head entry (valid when !empty_o)
//   full_o/empty_o: occupancy flags from the registered count
// Entry storage is deliberately left without reset.
module otbn_dmem_host_fifo
  import otbn_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  dmem_host_req_t push_data_i,
  input  logic           pop_i,
  output dmem_host_req_t head_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int unsigned PtrW = vbits(Depth);
  localparam int unsigned CntW = vbits(Depth + 1);

  dmem_host_req_t  storage_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) storage_q[wptr_q] <= push_data_i;
  end

  assign head_o = storage_q[rptr_q];

endmodule

// File: rtl/otbn_dmem_arb.sv
// OTBN DMEM arbiter: LSU has absolute priority on the memory port; host
// requests are queued and drained one per cycle whenever the LSU is idle.
// Host accesses drained while the core is busy are not forwarded: reads
// complete with rdata=0/rerror=1, writes are dropped, and host_busy_err_o
// pulses one cycle later.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   lsu_*               : core load/store unit request and read response
//   core_busy_i         : OTBN executing (blocks queued host accesses)
//   host_*              : host request (with host_gnt_o), read response, busy error
//   mem_*               : single-port DMEM, read data returned one cycle after request
//   host_stall_cnt_o    : (OTBN_DMEM_ARB_STATS_EN only) saturating count of
//                         cycles with a queued host request held off by the LSU
// Build option: define OTBN_DMEM_ARB_STATS_EN to add the stall counter.
module otbn_dmem_arb
  import otbn_pkg::*;
#(
  parameter  int unsigned DmemSizeByte  = 16384,
  parameter  int unsigned HostFifoDepth = 2,
  localparam int unsigned DmemAddrWidth = vbits(DmemSizeByte)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  input  logic                     lsu_req_i,
  input  logic                     lsu_write_i,
  input  logic [DmemAddrWidth-1:0] lsu_addr_i,
  input  logic [ExtWLEN-1:0]       lsu_wdata_i,
  input  logic [ExtWLEN-1:0]       lsu_wmask_i,
  output logic [ExtWLEN-1:0]       lsu_rdata_o,
  output logic                     lsu_rvalid_o,
  output logic                     lsu_rerror_o,
  input  logic                     core_busy_i,

  input  logic                     host_req_i,
  input  logic                     host_write_i,
  output logic                     host_gnt_o,
  input  logic [DmemAddrWidth-1:0] host_addr_i,
  input  logic [ExtWLEN-1:0]       host_wdata_i,
  input  logic [ExtWLEN-1:0]       host_wmask_i,
  output logic                     host_rvalid_o,
  output logic                     host_rerror_o,
  output logic [ExtWLEN-1:0]       host_rdata_o,
  output logic                     host_busy_err_o,

  output logic                     mem_req_o,
  output logic                     mem_write_o,
  output logic [DmemAddrWidth-1:0] mem_addr_o,
  output logic [ExtWLEN-1:0]       mem_wdata_o,
  output logic [ExtWLEN-1:0]       mem_wmask_o,
  input  logic [ExtWLEN-1:0]       mem_rdata_i,
  input  logic                     mem_rvalid_i,
  input  logic                     mem_rerror_i
`ifdef OTBN_DMEM_ARB_STATS_EN
  ,
  output logic [31:0]              host_stall_cnt_o
`endif
);

  dmem_host_req_t push_req, head_req;
  dmem_owner_e    owner_d, owner_q;
  logic           fifo_full, fifo_empty;
  logic           push, pop, host_fwd, host_blocked;
  logic           busy_err_q;
  logic           unused_head_addr;

  // Nothing is accepted or issued while reset is held: a push in a reset
  // cycle would be wiped by the same edge, so granting it would lie.
  assign host_gnt_o   = ~rst_i & ~fifo_full;
  assign push         = host_req_i & host_gnt_o;
  assign pop          = ~rst_i & ~lsu_req_i & ~fifo_empty;
  assign host_fwd     = pop & ~core_busy_i;
  assign host_blocked = pop & core_busy_i;

  assign push_req = '{
    addr:  DmemAddrMaxW'(host_addr_i),
    write: host_write_i,
    wdata: host_wdata_i,
    wmask: host_wmask_i
  };

  assign unused_head_addr = ^head_req.addr;

  otbn_dmem_host_fifo #(
    .Depth(HostFifoDepth)
  ) u_host_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_req),
    .pop_i       (pop),
    .head_o      (head_req),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (!rst_i) begin
      if (lsu_req_i) begin
        mem_req_o   = 1'b1;
        mem_write_o = lsu_write_i;
        mem_addr_o  = lsu_addr_i;
        mem_wdata_o = lsu_wdata_i;
        mem_wmask_o = lsu_wmask_i;
      end else if (host_fwd) begin
        mem_req_o   = 1'b1;
        mem_write_o = head_req.write;
        mem_addr_o  = head_req.addr[DmemAddrWidth-1:0];
        mem_wdata_o = head_req.wdata;
        mem_wmask_o = head_req.wmask;
      end
    end
  end

  // Owner tracks read responses only; forwarded writes produce no response.
  always_comb begin
    owner_d = OwnerNone;
    if (lsu_req_i) begin
      if (!lsu_write_i) owner_d = OwnerCore;
    end else if (host_fwd) begin
      if (!head_req.write) owner_d = OwnerHost;
    end else if (host_blocked) begin
      if (!head_req.write) owner_d = OwnerHostBlocked;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q    <= OwnerNone;
      busy_err_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      busy_err_q <= host_blocked;
    end
  end

  // Responses are suppressed while reset is held so an in-flight read
  // never surfaces.
  always_comb begin
    lsu_rvalid_o    = 1'b0;
    lsu_rerror_o    = 1'b0;
    lsu_rdata_o     = '0;
    host_rvalid_o   = 1'b0;
    host_rerror_o   = 1'b0;
    host_rdata_o    = '0;
    host_busy_err_o = 1'b0;
    if (!rst_i) begin
      host_busy_err_o = busy_err_q;
      case (owner_q)
        OwnerCore: begin
          lsu_rvalid_o = mem_rvalid_i;
          lsu_rerror_o = mem_rerror_i;
          lsu_rdata_o  = mem_rdata_i;
        end
        OwnerHost: begin
          host_rvalid_o = mem_rvalid_i;
          host_rerror_o = mem_rerror_i;
          host_rdata_o  = mem_rdata_i;
        end
        OwnerHostBlocked: begin
          host_rvalid_o = 1'b1;
          host_rerror_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef OTBN_DMEM_ARB_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (!fifo_empty && lsu_req_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign host_stall_cnt_o = stall_cnt_q;
`endif

endmodule
